// File: rtl/if_id_skid.sv
// Elastic IF/ID pipeline register with a 2-entry skid buffer, flush with drop accounting,
// NOP masking on bubbles and saturating stall/drop counters. Latency 1 cycle; up_ready is registered.
module if_id_skid #(
    parameter int             XLEN      = 32,
    parameter int             ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013),
    parameter int             CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [XLEN-1:0]  up_pc,
    input  logic [ILEN-1:0]  up_instr,
    input  logic             up_pred_taken,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [XLEN-1:0]  dn_pc,
    output logic [ILEN-1:0]  dn_instr,
    output logic             dn_pred_taken,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_drops
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            pred;
    } beat_t;

    // Encoding equals the entry count, and bit 1 alone marks a held SKID entry.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t state_q, state_d;
    beat_t  main_q, skid_q, up_beat;
    logic   main_v, skid_v;
    logic   up_fire, dn_fire;
    logic   load_main, load_skid, main_from_skid;

    assign main_v   = (state_q != EMPTY);
    assign skid_v   = state_q[1];
    assign up_ready = !state_q[1];
    assign up_fire  = up_valid && up_ready;
    assign dn_fire  = main_v && dn_ready;
    assign up_beat  = '{pc: up_pc, instr: up_instr, pred: up_pred_taken};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (up_fire) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (up_fire && dn_fire) begin
                    load_main = 1'b1;
                end else if (up_fire) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (dn_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (dn_fire) begin
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins: a same-cycle dn_fire still completes, everything else is squashed.
        if (flush) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    // Payload of an invalid entry is never observed, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_main) begin
            main_q <= up_beat;
        end else if (main_from_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= up_beat;
        end
    end

    logic [1:0]     drop_inc;
    logic [CNT_W:0] drop_sum;

    assign drop_inc = {1'b0, main_v && !dn_fire} + {1'b0, skid_v} + {1'b0, up_fire};
    assign drop_sum = {1'b0, flush_drops} + {{(CNT_W-1){1'b0}}, drop_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_drops  <= '0;
        end else begin
            if (!flush && up_valid && !up_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush) begin
                flush_drops <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
        end
    end

    assign dn_valid      = main_v;
    assign dn_pc         = main_v ? main_q.pc    : '0;
    assign dn_instr      = main_v ? main_q.instr : NOP_INSTR;
    assign dn_pred_taken = main_v && main_q.pred;
    assign occupancy     = state_q;

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed scenarios plus randomized traffic against a queue-based model.
module tb_if_id_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst, flush, up_valid, dn_ready, up_pred_taken;
    logic [31:0] up_pc, up_instr;

    logic        up_ready, dn_valid, dn_pred_taken;
    logic [31:0] dn_pc, dn_instr;
    logic [1:0]  occupancy;
    logic [15:0] stall_cycles, flush_drops;

    logic        up_ready4, dn_valid4, dn_pred_taken4;
    logic [31:0] dn_pc4, dn_instr4;
    logic [1:0]  occupancy4;
    logic [3:0]  stall4, drops4;

    int checks = 0;
    int errors = 0;

    if_id_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready), .up_pc(up_pc), .up_instr(up_instr),
        .up_pred_taken(up_pred_taken),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_pc(dn_pc), .dn_instr(dn_instr),
        .dn_pred_taken(dn_pred_taken), .occupancy(occupancy),
        .stall_cycles(stall_cycles), .flush_drops(flush_drops)
    );

    if_id_skid #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready4), .up_pc(up_pc), .up_instr(up_instr),
        .up_pred_taken(up_pred_taken),
        .dn_valid(dn_valid4), .dn_ready(dn_ready), .dn_pc(dn_pc4), .dn_instr(dn_instr4),
        .dn_pred_taken(dn_pred_taken4), .occupancy(occupancy4),
        .stall_cycles(stall4), .flush_drops(drops4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: an ordered list of held beats plus unsaturated event counts.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } beat_t;

    beat_t q[$];
    int    m_stall, m_drops;

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    function automatic logic [31:0] exp_pc();
        return (q.size() > 0) ? q[0].pc : 32'h0;
    endfunction

    function automatic logic [31:0] exp_instr();
        return (q.size() > 0) ? q[0].instr : NOP;
    endfunction

    function automatic logic exp_pred();
        return (q.size() > 0) ? q[0].pred : 1'b0;
    endfunction

    task automatic model_edge();
        int n;
        bit uf, df;
        n  = q.size();
        uf = up_valid && (n < 2);
        df = (n > 0) && dn_ready;
        if (flush) begin
            m_drops += ((n > 0 && !df) ? 1 : 0) + ((n == 2) ? 1 : 0) + (uf ? 1 : 0);
            q.delete();
        end else begin
            if (up_valid && n == 2) m_stall++;
            if (df) void'(q.pop_front());
            if (uf) q.push_back(beat_t'{up_pc, up_instr, up_pred_taken});
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
        up_pc = '0; up_instr = '0; up_pred_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_stall = 0;
        m_drops = 0;
    endtask

    task automatic drive(input logic [31:0] pc);
        up_valid = 1'b1;
        up_pc = pc;
        up_instr = pc ^ 32'hA5A5_0000;
        up_pred_taken = pc[2];
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready got %b exp 1", up_ready); end
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL reset_dn_valid got %b exp 0", dn_valid); end
        checks++; if (dn_instr !== NOP) begin errors++; $display("FAIL reset_dn_instr got %h exp %h", dn_instr, NOP); end
        checks++; if (dn_pc !== 32'h0 || dn_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_dn_pc_pred got %h/%b exp 0/0", dn_pc, dn_pred_taken); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        checks++; if (stall_cycles !== 16'd0 || flush_drops !== 16'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cycles, flush_drops); end
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        do_reset();
        dn_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(pcs[i]);
            tick();
            checks++; if (dn_valid !== 1'b1 || dn_pc !== pcs[i]) begin errors++; $display("FAIL stream_beat%0d got v=%b pc=%h exp v=1 pc=%h", i, dn_valid, dn_pc, pcs[i]); end
            checks++; if (dn_instr !== (pcs[i] ^ 32'hA5A5_0000) || dn_pred_taken !== pcs[i][2]) begin errors++; $display("FAIL stream_payload%0d got %h/%b", i, dn_instr, dn_pred_taken); end
            checks++; if (occupancy !== 2'd1 || up_ready !== 1'b1) begin errors++; $display("FAIL stream_occ%0d got occ=%0d rdy=%b exp 1/1", i, occupancy, up_ready); end
        end
        up_valid = 1'b0;
        tick();
        checks++; if (dn_valid !== 1'b0 || stall_cycles !== 16'd0) begin errors++; $display("FAIL stream_drain got v=%b stall=%0d exp 0/0", dn_valid, stall_cycles); end
    endtask

    task automatic test_backpressure();
        logic [31:0] seen[$];
        bit acc;
        do_reset();
        drive(32'h200); tick();
        drive(32'h204); tick();
        drive(32'h208);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (up_ready !== 1'b0 || occupancy !== 2'd2 || dn_pc !== 32'h200) begin errors++; $display("FAIL bp_hold%0d got rdy=%b occ=%0d pc=%h exp 0/2/200", i, up_ready, occupancy, dn_pc); end
            tick();
        end
        checks++; if (stall_cycles !== 16'd4) begin errors++; $display("FAIL bp_stall got %0d exp 4", stall_cycles); end
        dn_ready = 1'b1;
        for (int c = 0; c < 10 && seen.size() < 3; c++) begin
            if (dn_valid) seen.push_back(dn_pc);
            acc = up_valid && up_ready;
            tick();
            if (acc) up_valid = 1'b0;
        end
        checks++; if (seen.size() != 3) begin errors++; $display("FAIL bp_count got %0d beats exp 3", seen.size()); end
        else begin
            checks++; if (seen[0] !== 32'h200 || seen[1] !== 32'h204 || seen[2] !== 32'h208) begin errors++; $display("FAIL bp_order got %h %h %h exp 200 204 208", seen[0], seen[1], seen[2]); end
        end
        checks++; if (stall_cycles !== 16'd5 || m_stall != 5) begin errors++; $display("FAIL bp_stall_total got %0d exp 5", stall_cycles); end
    endtask

    task automatic test_flush_full();
        do_reset();
        drive(32'h300); tick();
        drive(32'h304); tick();
        drive(32'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0; up_valid = 1'b0;
        checks++; if (dn_valid !== 1'b0 || dn_instr !== NOP) begin errors++; $display("FAIL flushfull_dn got v=%b instr=%h exp 0/%h", dn_valid, dn_instr, NOP); end
        checks++; if (occupancy !== 2'd0 || up_ready !== 1'b1) begin errors++; $display("FAIL flushfull_occ got occ=%0d rdy=%b exp 0/1", occupancy, up_ready); end
        checks++; if (flush_drops !== 16'd2) begin errors++; $display("FAIL flushfull_drops got %0d exp 2", flush_drops); end
    endtask

    task automatic test_flush_one();
        do_reset();
        drive(32'h400); tick();
        drive(32'h404);
        dn_ready = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (dn_valid !== 1'b1 || dn_pc !== 32'h400 || up_ready !== 1'b1) begin errors++; $display("FAIL flushone_fire got v=%b pc=%h rdy=%b exp 1/400/1", dn_valid, dn_pc, up_ready); end
        tick();
        flush = 1'b0; up_valid = 1'b0;
        checks++; if (occupancy !== 2'd0 || dn_valid !== 1'b0 || up_ready !== 1'b1) begin errors++; $display("FAIL flushone_empty got occ=%0d v=%b rdy=%b exp 0/0/1", occupancy, dn_valid, up_ready); end
        checks++; if (flush_drops !== 16'd1) begin errors++; $display("FAIL flushone_drops got %0d exp 1", flush_drops); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(32'h500); tick();
        drive(32'h504); tick();
        drive(32'h508);
        repeat (20) tick();
        checks++; if (stall4 !== 4'd15) begin errors++; $display("FAIL sat_stall4 got %0d exp 15", stall4); end
        checks++; if (stall_cycles !== 16'd20) begin errors++; $display("FAIL sat_stall16 got %0d exp 20", stall_cycles); end
        tick();
        checks++; if (stall4 !== 4'd15) begin errors++; $display("FAIL sat_hold4 got %0d exp 15", stall4); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(32'h600); tick();
        drive(32'h604); tick();
        drive(32'h608);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (up_ready !== 1'b1 || dn_valid !== 1'b0 || dn_instr !== NOP) begin errors++; $display("FAIL arst_out got rdy=%b v=%b instr=%h exp 1/0/%h", up_ready, dn_valid, dn_instr, NOP); end
        checks++; if (stall_cycles !== 16'd0 || occupancy !== 2'd0) begin errors++; $display("FAIL arst_state got stall=%0d occ=%0d exp 0/0", stall_cycles, occupancy); end
        up_valid = 1'b0; dn_ready = 1'b0;
        q.delete(); m_stall = 0; m_drops = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        drive(32'h610);
        tick();
        up_valid = 1'b0;
        checks++; if (dn_valid !== 1'b1 || dn_pc !== 32'h610) begin errors++; $display("FAIL arst_first got v=%b pc=%h exp 1/610", dn_valid, dn_pc); end
    endtask

    task automatic test_random();
        bit acc;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!up_valid) begin
                up_valid = ($urandom_range(0, 3) != 0);
                up_pc = $urandom;
                up_instr = $urandom;
                up_pred_taken = $urandom_range(0, 1) == 1;
            end
            dn_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            #1;
            checks++; if (dn_valid !== (q.size() > 0) || occupancy !== 2'(q.size()) || up_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL rnd_ctrl cyc %0d got v=%b occ=%0d rdy=%b exp size %0d", c, dn_valid, occupancy, up_ready, q.size());
            end
            checks++; if (dn_pc !== exp_pc() || dn_instr !== exp_instr() || dn_pred_taken !== exp_pred()) begin
                errors++; $display("FAIL rnd_data cyc %0d got %h/%h/%b exp %h/%h/%b", c, dn_pc, dn_instr, dn_pred_taken, exp_pc(), exp_instr(), exp_pred());
            end
            checks++; if (stall_cycles !== 16'(sat(m_stall, 16)) || flush_drops !== 16'(sat(m_drops, 16))) begin
                errors++; $display("FAIL rnd_cnt16 cyc %0d got %0d/%0d exp %0d/%0d", c, stall_cycles, flush_drops, m_stall, m_drops);
            end
            checks++; if (stall4 !== 4'(sat(m_stall, 4)) || drops4 !== 4'(sat(m_drops, 4))) begin
                errors++; $display("FAIL rnd_cnt4 cyc %0d got %0d/%0d exp %0d/%0d", c, stall4, drops4, sat(m_stall, 4), sat(m_drops, 4));
            end
            acc = up_valid && (q.size() < 2);
            tick();
            if (acc) up_valid = 1'b0;
        end
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_flush_one();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
